// File: rtl/wb_periph_bridge.sv
// Data-bus to Wishbone bridge: address-decodes one of N_SLV slaves and runs one transfer at a time.
// Latency 3 cycles minimum (request, BUS, RESP); requests outside IDLE are ignored, so the core holds until valid.
module wb_periph_bridge #(
    parameter int                        N_SLV    = 4,
    parameter int                        ADDR_W   = 16,
    parameter logic [N_SLV*ADDR_W-1:0]   SLV_BASE = {16'h4000, 16'h3000, 16'h2000, 16'h1000},
    parameter logic [N_SLV*ADDR_W-1:0]   SLV_MASK = {4{16'hF000}},
    parameter int                        TIMEOUT  = 255
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [31:0]          dbus_addr,
    input  logic [31:0]          dbus_wdata,
    input  logic                 dbus_rd_en,
    input  logic                 dbus_wr_en,
    input  logic [1:0]           dbus_st_type,
    output logic [31:0]          dbus_rdata,
    output logic                 dbus_valid,
    output logic                 dbus_err,
    output logic [ADDR_W-1:0]    wbm_m2s_addr,
    output logic [31:0]          wbm_m2s_data,
    output logic                 wbm_m2s_we,
    output logic [3:0]           wbm_m2s_sel,
    output logic                 wbm_m2s_stb,
    output logic [N_SLV-1:0]     slv_addr_sel,
    input  logic [N_SLV-1:0]     slv_ack_i,
    input  logic [32*N_SLV-1:0]  slv_data_i
);
    localparam int IDX_W = (N_SLV > 1) ? $clog2(N_SLV) : 1;

    typedef enum logic [1:0] {IDLE, BUS, RESP, ERR} state_t;
    state_t state, state_nxt;

    logic [IDX_W-1:0] slv_idx, hit_idx;
    logic             hit;
    logic             req;
    logic [15:0]      wait_cnt;
    logic [3:0]       sel_nxt;
    logic [31:0]      wdata_nxt;
    logic             ack_sel;
    logic             cnt_done;

    assign req      = dbus_rd_en | dbus_wr_en;
    assign ack_sel  = slv_ack_i[slv_idx];
    assign cnt_done = (wait_cnt == 16'(TIMEOUT));

    // Descending scan so the lowest matching index is the one left standing.
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int i = N_SLV - 1; i >= 0; i--) begin
            if (((dbus_addr[ADDR_W-1:0] & SLV_MASK[i*ADDR_W +: ADDR_W]) == SLV_BASE[i*ADDR_W +: ADDR_W]) &&
                (dbus_addr[31:ADDR_W] == '0)) begin
                hit     = 1'b1;
                hit_idx = IDX_W'(i);
            end
        end
    end

    always_comb begin
        sel_nxt   = 4'b1111;
        wdata_nxt = dbus_wdata;
        if (dbus_wr_en) begin
            case (dbus_st_type)
                2'b01: sel_nxt = 4'b1111;
                2'b10: begin
                    sel_nxt   = dbus_addr[1] ? 4'b1100 : 4'b0011;
                    wdata_nxt = {2{dbus_wdata[15:0]}};
                end
                2'b11: begin
                    sel_nxt   = 4'b0001 << dbus_addr[1:0];
                    wdata_nxt = {4{dbus_wdata[7:0]}};
                end
                default: sel_nxt = 4'b0000;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (req) state_nxt = hit ? BUS : ERR;
            BUS: begin
                if (ack_sel)       state_nxt = RESP;
                else if (cnt_done) state_nxt = ERR;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wbm_m2s_addr <= '0;
            wbm_m2s_data <= '0;
            wbm_m2s_we   <= 1'b0;
            wbm_m2s_sel  <= '0;
            slv_idx      <= '0;
            wait_cnt     <= '0;
            dbus_rdata   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    wait_cnt <= '0;
                    if (req && hit) begin
                        wbm_m2s_addr <= dbus_addr[ADDR_W-1:0];
                        wbm_m2s_data <= wdata_nxt;
                        wbm_m2s_we   <= dbus_wr_en;
                        wbm_m2s_sel  <= sel_nxt;
                        slv_idx      <= hit_idx;
                    end else if (req) begin
                        dbus_rdata <= 32'hDEAD_BEEF;
                    end
                end
                BUS: begin
                    // An ack on the final counted cycle still wins over the timeout.
                    if (ack_sel)       dbus_rdata <= wbm_m2s_we ? 32'h0 : slv_data_i[32*slv_idx +: 32];
                    else if (cnt_done) dbus_rdata <= 32'hDEAD_BEEF;
                    else               wait_cnt   <= wait_cnt + 16'd1;
                end
                default: ;
            endcase
        end
    end

    assign wbm_m2s_stb  = (state == BUS);
    assign slv_addr_sel = (state == BUS) ? (N_SLV'(1) << slv_idx) : '0;
    assign dbus_valid   = (state == RESP) || (state == ERR);
    assign dbus_err     = (state == ERR);
endmodule

// File: tb/tb_wb_periph_bridge.sv
// Directed bench for wb_periph_bridge: a default instance plus a TIMEOUT=3 instance for timeout cases.
module tb_wb_periph_bridge;
    logic         clk = 1'b0;
    logic         rst_n;
    logic [31:0]  dbus_addr, dbus_wdata;
    logic         rd_en, wr_en, rd_en2, wr_en2;
    logic [1:0]   st_type;
    logic [3:0]   ack, ack2;
    logic [127:0] sdata;

    logic [31:0]  rdata, rdata2, wbm_data, wbm_data2;
    logic         valid, err, valid2, err2, we, we2, stb, stb2;
    logic [15:0]  wbm_addr, wbm_addr2;
    logic [3:0]   sel, sel2, addr_sel, addr_sel2;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    wb_periph_bridge u_dut (
        .clk(clk), .rst_n(rst_n),
        .dbus_addr(dbus_addr), .dbus_wdata(dbus_wdata), .dbus_rd_en(rd_en), .dbus_wr_en(wr_en),
        .dbus_st_type(st_type), .dbus_rdata(rdata), .dbus_valid(valid), .dbus_err(err),
        .wbm_m2s_addr(wbm_addr), .wbm_m2s_data(wbm_data), .wbm_m2s_we(we), .wbm_m2s_sel(sel),
        .wbm_m2s_stb(stb), .slv_addr_sel(addr_sel), .slv_ack_i(ack), .slv_data_i(sdata)
    );

    wb_periph_bridge #(.TIMEOUT(3)) u_dut_to (
        .clk(clk), .rst_n(rst_n),
        .dbus_addr(dbus_addr), .dbus_wdata(dbus_wdata), .dbus_rd_en(rd_en2), .dbus_wr_en(wr_en2),
        .dbus_st_type(st_type), .dbus_rdata(rdata2), .dbus_valid(valid2), .dbus_err(err2),
        .wbm_m2s_addr(wbm_addr2), .wbm_m2s_data(wbm_data2), .wbm_m2s_we(we2), .wbm_m2s_sel(sel2),
        .wbm_m2s_stb(stb2), .slv_addr_sel(addr_sel2), .slv_ack_i(ack2), .slv_data_i(sdata)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        vectors++; if ({stb, addr_sel, valid, err} !== 7'b0) begin miscompares++; $display("FAIL rst_ctl: got %b want 0", {stb, addr_sel, valid, err}); end
        vectors++; if (rdata !== 32'h0) begin miscompares++; $display("FAIL rst_rdata: got %h want 0", rdata); end
        vectors++; if ({wbm_addr, wbm_data, we, sel} !== 53'h0) begin miscompares++; $display("FAIL rst_wbm: got %h want 0", {wbm_addr, wbm_data, we, sel}); end
    endtask

    task automatic test_read;
        dbus_addr = 32'h0000_2010; rd_en = 1'b1;
        sdata[63:32] = 32'h1234_5678;
        tick;
        rd_en = 1'b0; ack = 4'b0010;
        vectors++; if (stb !== 1'b1 || addr_sel !== 4'b0010) begin miscompares++; $display("FAIL rd_bus: got stb=%b addr_sel=%b want 1/0010", stb, addr_sel); end
        vectors++; if (sel !== 4'b1111 || we !== 1'b0 || wbm_addr !== 16'h2010) begin miscompares++; $display("FAIL rd_wbm: got sel=%b we=%b addr=%h want 1111/0/2010", sel, we, wbm_addr); end
        tick;
        ack = 4'b0000;
        vectors++; if (valid !== 1'b1 || err !== 1'b0 || rdata !== 32'h1234_5678) begin miscompares++; $display("FAIL rd_resp: got v=%b e=%b d=%h want 1/0/12345678", valid, err, rdata); end
        vectors++; if (stb !== 1'b0) begin miscompares++; $display("FAIL rd_stb_drop: got %b want 0", stb); end
        tick;
        vectors++; if (valid !== 1'b0) begin miscompares++; $display("FAIL rd_valid_once: got %b want 0", valid); end
    endtask

    task automatic test_byte_write;
        int n_stb = 0;
        dbus_addr = 32'h0000_3003; dbus_wdata = 32'h0000_00AB; st_type = 2'b11; wr_en = 1'b1;
        tick;
        wr_en = 1'b0;
        vectors++; if (we !== 1'b1 || sel !== 4'b1000 || wbm_data !== 32'hABAB_ABAB || addr_sel !== 4'b0100) begin
            miscompares++; $display("FAIL bw_bus: got we=%b sel=%b d=%h as=%b want 1/1000/abababab/0100", we, sel, wbm_data, addr_sel); end
        for (int i = 0; i < 5; i++) begin
            if (stb === 1'b1 && wbm_data === 32'hABAB_ABAB) n_stb++;
            tick;
        end
        ack = 4'b0100;
        vectors++; if (n_stb !== 5 || stb !== 1'b1 || valid !== 1'b0) begin miscompares++; $display("FAIL bw_hold: got stable=%0d stb=%b valid=%b want 5/1/0", n_stb, stb, valid); end
        tick;
        ack = 4'b0000;
        vectors++; if (valid !== 1'b1 || err !== 1'b0 || rdata !== 32'h0) begin miscompares++; $display("FAIL bw_resp: got v=%b e=%b d=%h want 1/0/0", valid, err, rdata); end
        tick;
    endtask

    task automatic test_sel;
        dbus_addr = 32'h0000_4000; dbus_wdata = 32'h89AB_CDEF; st_type = 2'b01; wr_en = 1'b1;
        tick;
        wr_en = 1'b0; ack = 4'b1000;
        vectors++; if (sel !== 4'b1111 || wbm_data !== 32'h89AB_CDEF || addr_sel !== 4'b1000) begin
            miscompares++; $display("FAIL ww_bus: got sel=%b d=%h as=%b want 1111/89abcdef/1000", sel, wbm_data, addr_sel); end
        tick; ack = 4'b0000; tick;
        dbus_addr = 32'h0000_1006; st_type = 2'b10; wr_en = 1'b1;
        tick;
        wr_en = 1'b0; ack = 4'b0001;
        vectors++; if (sel !== 4'b1100 || wbm_data !== 32'hCDEF_CDEF || addr_sel !== 4'b0001) begin
            miscompares++; $display("FAIL hw_bus: got sel=%b d=%h as=%b want 1100/cdefcdef/0001", sel, wbm_data, addr_sel); end
        tick; ack = 4'b0000; tick;
        dbus_addr = 32'h0000_1000; st_type = 2'b00; wr_en = 1'b1;
        tick;
        wr_en = 1'b0; ack = 4'b0001;
        vectors++; if (sel !== 4'b0000 || we !== 1'b1) begin miscompares++; $display("FAIL none_sel: got sel=%b we=%b want 0000/1", sel, we); end
        tick; ack = 4'b0000; tick;
    endtask

    task automatic test_miss;
        dbus_addr = 32'h0000_9000; rd_en = 1'b1;
        tick;
        rd_en = 1'b0;
        vectors++; if (valid !== 1'b1 || err !== 1'b1 || rdata !== 32'hDEAD_BEEF || stb !== 1'b0) begin
            miscompares++; $display("FAIL miss_err: got v=%b e=%b d=%h stb=%b want 1/1/deadbeef/0", valid, err, rdata, stb); end
        tick;
        vectors++; if (valid !== 1'b0 || err !== 1'b0) begin miscompares++; $display("FAIL miss_once: got v=%b e=%b want 0/0", valid, err); end
        dbus_addr = 32'h0001_1000; rd_en = 1'b1;
        tick;
        rd_en = 1'b0;
        vectors++; if (err !== 1'b1 || stb !== 1'b0) begin miscompares++; $display("FAIL miss_upper: got e=%b stb=%b want 1/0", err, stb); end
        tick;
    endtask

    task automatic test_timeout;
        int n = 0;
        dbus_addr = 32'h0000_1000; rd_en2 = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick;
            if (i == 0) begin rd_en2 = 1'b0; ack2 = 4'b0100; end
            if (stb2 === 1'b1) n++;
            else break;
        end
        ack2 = 4'b0000;
        vectors++; if (n !== 4) begin miscompares++; $display("FAIL to_stb_len: got %0d want 4", n); end
        vectors++; if (valid2 !== 1'b1 || err2 !== 1'b1 || rdata2 !== 32'hDEAD_BEEF) begin
            miscompares++; $display("FAIL to_err: got v=%b e=%b d=%h want 1/1/deadbeef", valid2, err2, rdata2); end
        tick;
        // Ack arriving on the last counted cycle still completes normally.
        sdata[31:0] = 32'h0BAD_F00D; rd_en2 = 1'b1;
        tick;
        rd_en2 = 1'b0;
        tick; tick; tick;
        ack2 = 4'b0001;
        vectors++; if (stb2 !== 1'b1) begin miscompares++; $display("FAIL to_edge_stb: got %b want 1", stb2); end
        tick;
        ack2 = 4'b0000;
        vectors++; if (valid2 !== 1'b1 || err2 !== 1'b0 || rdata2 !== 32'h0BAD_F00D) begin
            miscompares++; $display("FAIL to_edge_ack: got v=%b e=%b d=%h want 1/0/0badf00d", valid2, err2, rdata2); end
        tick;
    endtask

    task automatic test_reset_mid;
        dbus_addr = 32'h0000_3000; rd_en = 1'b1;
        tick;
        rd_en = 1'b0;
        vectors++; if (stb !== 1'b1) begin miscompares++; $display("FAIL rm_bus: got stb=%b want 1", stb); end
        #1 rst_n = 1'b0;
        #1;
        vectors++; if (stb !== 1'b0 || addr_sel !== 4'b0000 || rdata !== 32'h0 || wbm_addr !== 16'h0) begin
            miscompares++; $display("FAIL rm_async: got stb=%b as=%b d=%h a=%h want 0/0/0/0", stb, addr_sel, rdata, wbm_addr); end
        ack = 4'b0100;
        #1 rst_n = 1'b1;
        ack = 4'b0000;
        dbus_addr = 32'h0000_1002; dbus_wdata = 32'h0000_CDEF; st_type = 2'b10; wr_en = 1'b1;
        tick;
        wr_en = 1'b0; ack = 4'b0001;
        vectors++; if (valid !== 1'b0 || stb !== 1'b1 || sel !== 4'b1100 || addr_sel !== 4'b0001) begin
            miscompares++; $display("FAIL rm_next_bus: got v=%b stb=%b sel=%b as=%b want 0/1/1100/0001", valid, stb, sel, addr_sel); end
        tick;
        ack = 4'b0000;
        vectors++; if (valid !== 1'b1 || err !== 1'b0) begin miscompares++; $display("FAIL rm_next_resp: got v=%b e=%b want 1/0", valid, err); end
        tick;
    endtask

    task automatic test_back_to_back;
        logic [5:0] vhist, shist;
        vhist = '0; shist = '0;
        dbus_addr = 32'h0000_1004; rd_en = 1'b1; ack = 4'b0001;
        for (int i = 0; i < 6; i++) begin
            tick;
            vhist[i] = valid;
            shist[i] = stb;
        end
        rd_en = 1'b0;
        for (int i = 0; i < 3; i++) tick;
        ack = 4'b0000;
        tick;
        vectors++; if (vhist !== 6'b010010) begin miscompares++; $display("FAIL b2b_valid: got %b want 010010", vhist); end
        vectors++; if (shist !== 6'b001001) begin miscompares++; $display("FAIL b2b_stb: got %b want 001001", shist); end
        vectors++; if (valid !== 1'b0 || stb !== 1'b0) begin miscompares++; $display("FAIL b2b_idle: got v=%b stb=%b want 0/0", valid, stb); end
    endtask

    initial begin
        rst_n = 1'b0;
        dbus_addr = '0; dbus_wdata = '0; rd_en = 1'b0; wr_en = 1'b0; rd_en2 = 1'b0; wr_en2 = 1'b0;
        st_type = 2'b00; ack = '0; ack2 = '0; sdata = '0;
        #12;
        test_reset;
        @(negedge clk);
        rst_n = 1'b1;
        tick;
        test_read;
        test_byte_write;
        test_sel;
        test_miss;
        test_timeout;
        test_reset_mid;
        test_back_to_back;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
